prio_serialiser: RTL and testbench

Parametrised, registered priority encoder that accepts an N-bit request vector over a valid/ready handshake and emits the index of every set bit, one per accepted output beat. Each vector is drained in either fixed (highest index first) or round-robin order. The block sits between a request-collecting front end and a consumer that services one index per beat. An all-zero vector produces an explicit "none" beat.

---
 rtl/prio_pkg.sv | 17 +
 rtl/prio_pick.sv | 36 +++
 rtl/prio_serialiser.sv | 81 ++++++++
 tb/tb_prio_serialiser.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_pkg.sv
// Shared constants and helpers for the priority serialiser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prio_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Widest request vector the helper below accepts; callers zero-extend.
  localparam int MAX_N = 256;

  // True when exactly one bit of vec is set.
  function automatic logic popcount_is_one(input logic [MAX_N-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_N'(1))) == '0);
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: index of the highest set bit, optionally searched
// downward from a start position with wrap-around.
// Latency: 0 cycles. Backpressure: none (pure logic).
// Ports: vec (request bits), start (round-robin search start),
//        rr (1 = search from start, 0 = plain highest-set), idx (result).
module prio_pick #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  input  logic             rr,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0] rot;
  int           off;
  int           top;

  // Rotate so that bit 'start' sits at the top; a plain highest-set search
  // on the rotated vector then walks start, start-1, ..., 0, N-1, ..., start+1.
  // In fixed mode the rotation amount is zero.
  always_comb begin
    off = rr ? int'(start) + 1 : 0;
    rot = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = vec[IDX_W'((j + off) % N)];
    end
    top = 0;
    for (int j = 0; j < N; j++) begin
      if (rot[j]) top = j;
    end
    idx = IDX_W'((top + off) % N);
  end

endmodule

// File: rtl/prio_serialiser.sv
// Loads an N-bit request vector and emits the index of each set bit, one per
// accepted beat, in fixed (highest first) or round-robin order.
// Latency: first beat 1 cycle after load; 1 beat/cycle; empty vector = 1 "none" beat.
// Backpressure: out_ready low holds the beat and ptr; in_ready only while idle.
// Ports: clk, rst_n (sync, active low); in_vec/in_mode/in_valid/in_ready load side;
//        out_idx/out_none/out_last/out_valid/out_ready beat side; busy.
module prio_serialiser
  import prio_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_vec,
  input  logic             in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_none,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  logic [N-1:0]     pend;
  logic             none_f;
  logic             mode_r;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             load;
  logic             beat;

  prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .vec   (pend),
    .start (ptr),
    .rr    (mode_r == MODE_RR),
    .idx   (pick_idx)
  );

  assign busy      = (pend != '0) || none_f;
  assign in_ready  = !busy;
  assign out_valid = busy;
  assign out_none  = none_f;
  // Force index 0 for the none beat and while idle so the bus is quiet.
  assign out_idx   = (none_f || !busy) ? '0 : pick_idx;
  assign out_last  = none_f || popcount_is_one(MAX_N'(pend));

  // Loads only happen while idle and beats only while busy, so the two are
  // mutually exclusive.
  assign load = in_valid && in_ready;
  assign beat = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend   <= '0;
      none_f <= 1'b0;
      mode_r <= MODE_FIXED;
      ptr    <= IDX_W'(N - 1);
    end else if (load) begin
      pend   <= in_vec;
      mode_r <= in_mode;
      none_f <= (in_vec == '0);
    end else if (beat) begin
      if (none_f) begin
        none_f <= 1'b0;
      end else begin
        pend[pick_idx] <= 1'b0;
      end
      // Next search starts just below the granted index, wrapping 0 -> N-1.
      if (mode_r == MODE_RR) begin
        ptr <= (out_idx == '0) ? IDX_W'(N - 1) : out_idx - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prio_serialiser.sv
// Self-checking bench for prio_serialiser (N = 16): table-driven vectors,
// hand-written backpressure and reset sequences, and random vectors checked
// against a scoreboard fed by a behavioural model.
module tb_prio_serialiser;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_vec;
  logic        in_mode;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_idx;
  logic        out_none;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  prio_serialiser #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vec    (in_vec),
    .in_mode   (in_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_idx   (out_idx),
    .out_none  (out_none),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] idx;
    logic       last;
    logic       none;
  } beat_t;

  // nb = 0 means the vector is all-zero and yields one none beat.
  // beats holds up to four expected indices, first beat in the top nibble.
  typedef struct {
    logic [15:0] vec;
    logic        mode;
    int          nb;
    logic [15:0] beats;
  } vec_t;

  beat_t exp_q[$];
  vec_t  tab[7];
  int    nvec = 0;
  int    nerr = 0;
  logic  rdy_chk = 1'b0;
  logic [3:0] mptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard side: compare every accepted beat with the head of the queue.
  always @(negedge clk) begin
    beat_t e;
    if (rdy_chk) begin
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_beat: got idx %0d none %0b, want no beat at %0t",
                 out_idx, out_none, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_idx", 32'(out_idx), 32'(e.idx));
        chk("out_last", 32'(out_last), 32'(e.last));
        chk("out_none", 32'(out_none), 32'(e.none));
      end
    end
  end

  // Behavioural model: walks the set bits directly, tracking its own pointer.
  task automatic model(input logic [15:0] v, input logic m, input bit push);
    logic [15:0] p;
    int          k;
    beat_t       e;
    if (v == 16'h0) begin
      if (push) exp_q.push_back('{4'd0, 1'b1, 1'b1});
      if (m) mptr = 4'hF;
      return;
    end
    p = v;
    while (p != 16'h0) begin
      k = -1;
      if (m) begin
        for (int s = 0; s < 16; s++) begin
          automatic int c = (int'(mptr) - s + 16) % 16;
          if (k < 0 && p[c]) k = c;
        end
      end else begin
        for (int s = 15; s >= 0; s--) begin
          if (k < 0 && p[s]) k = s;
        end
      end
      p[k]   = 1'b0;
      e.idx  = 4'(k);
      e.last = (p == 16'h0);
      e.none = 1'b0;
      if (push) exp_q.push_back(e);
      if (m) mptr = 4'((k + 15) % 16);
    end
  endtask

  task automatic push_tab(input vec_t t);
    if (t.nb == 0) begin
      exp_q.push_back('{4'd0, 1'b1, 1'b1});
    end else begin
      for (int b = 0; b < t.nb; b++) begin
        exp_q.push_back('{t.beats[15-4*b -: 4], (b == t.nb - 1), 1'b0});
      end
    end
  endtask

  // Present one vector for exactly one loading edge; returns 1 ns after it.
  task automatic send(input logic [15:0] v, input logic m);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout: in_ready %0b, want 1", in_ready);
    end
    in_vec   = v;
    in_mode  = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vec   = 16'h0;
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    rdy_chk = 1'b1;
    while ((busy || exp_q.size() != 0) && n < 600) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    if (n >= 600) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout: %0d beats outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    rdy_chk = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    in_vec    = 16'h0;
    in_mode   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mptr      = 4'hF;

    tab[0] = '{16'h8421, 1'b0, 4, 16'hFA50};  // 15,10,5,0
    tab[1] = '{16'h0000, 1'b0, 0, 16'h0000};  // none beat
    tab[2] = '{16'h0400, 1'b1, 1, 16'hA000};  // 10, ptr -> 9
    tab[3] = '{16'h8200, 1'b1, 2, 16'h9F00};  // 9 then 15
    tab[4] = '{16'h0001, 1'b1, 1, 16'h0000};  // 0, ptr -> 15
    tab[5] = '{16'h8002, 1'b1, 2, 16'hF100};  // 15 then 1
    tab[6] = '{16'h0003, 1'b0, 2, 16'h1000};  // fixed: 1 then 0

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_none", 32'(out_none), 32'd0);
    chk("rst_ptr", 32'(dut.ptr), 32'd15);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      push_tab(tab[i]);
      model(tab[i].vec, tab[i].mode, 1'b0);
      send(tab[i].vec, tab[i].mode);
      drain(1'b0);
    end
    chk("rr_ptr_after_tab", 32'(dut.ptr), 32'(mptr));

    // Backpressure: first beat must hold for three stalled cycles.
    model(16'h8001, 1'b0, 1'b1);
    send(16'h8001, 1'b0);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_idx", 32'(out_idx), 32'd15);
      chk("bp_last", 32'(out_last), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain(1'b0);

    // Random vectors with random backpressure.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] v;
      logic        m;
      v = 16'($urandom) & 16'($urandom);
      if (i % 7 == 3) v = 16'h0;
      m = 1'($urandom_range(0, 1));
      model(v, m, 1'b1);
      send(v, m);
      drain(1'b1);
    end

    // Reset in the middle of a drain.
    out_ready = 1'b1;
    exp_q.push_back('{4'd15, 1'b0, 1'b0});
    exp_q.push_back('{4'd14, 1'b0, 1'b0});
    exp_q.push_back('{4'd13, 1'b0, 1'b0});
    send(16'hFFFF, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_ptr", 32'(dut.ptr), 32'd15);
    chk("mid_rst_beats_left", 32'(exp_q.size()), 32'd0);
    mptr = 4'hF;
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back('{4'd4, 1'b1, 1'b0});
    model(16'h0010, 1'b1, 1'b0);
    send(16'h0010, 1'b1);
    drain(1'b0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
